// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit with start/ready handshake and abort-on-restart.
// Optional macro MULTDIV_BOOTH4_EN selects radix-4 Booth multiply (WIDTH/2 iterations).
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN_MUL = 2'd1;
    localparam logic [1:0] ST_RUN_DIV = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    // Product register: two guard bits above the accumulator so +/-2M never wraps.
    localparam int PW = 2 * WIDTH + 3;
    localparam int UW = WIDTH + 2;

`ifdef MULTDIV_BOOTH4_EN
    localparam int MUL_ITERS = WIDTH / 2;
`else
    localparam int MUL_ITERS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        mag = v[WIDTH-1] ? (~v + one) : v;
    endfunction

    logic [1:0]       state_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_mul_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    prod_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] result_r;
    logic             exc_r;
    logic             rdy_r;

    logic             start_mul_s;
    logic             start_div_s;
    logic [UW-1:0]    mext_s;
    logic [UW-1:0]    upper_s;
    logic [PW-1:0]    prod_nxt_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic [2*WIDTH-1:0] full_prod_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             fin_exc_s;

    assign start_mul_s = ctrl_MULT & ~ctrl_DIV;
    assign start_div_s = ctrl_DIV & ~ctrl_MULT;
    assign mext_s      = {{2{a_r[WIDTH-1]}}, a_r};

`ifdef MULTDIV_BOOTH4_EN
    logic [UW-1:0] m2_s;
    assign m2_s = {mext_s[UW-2:0], 1'b0};

    // Radix-4 Booth step: recode three multiplier bits, add, shift two places.
    always_comb begin
        upper_s = prod_r[PW-1:WIDTH+1];
        case (prod_r[2:0])
            3'b001, 3'b010: upper_s = prod_r[PW-1:WIDTH+1] + mext_s;
            3'b011:         upper_s = prod_r[PW-1:WIDTH+1] + m2_s;
            3'b100:         upper_s = prod_r[PW-1:WIDTH+1] - m2_s;
            3'b101, 3'b110: upper_s = prod_r[PW-1:WIDTH+1] - mext_s;
            default:        upper_s = prod_r[PW-1:WIDTH+1];
        endcase
        prod_nxt_s = {{2{upper_s[UW-1]}}, upper_s, prod_r[WIDTH:2]};
    end
`else
    // Radix-2 Booth step: recode two multiplier bits, add, shift one place.
    always_comb begin
        upper_s = prod_r[PW-1:WIDTH+1];
        case (prod_r[1:0])
            2'b01:   upper_s = prod_r[PW-1:WIDTH+1] + mext_s;
            2'b10:   upper_s = prod_r[PW-1:WIDTH+1] - mext_s;
            default: upper_s = prod_r[PW-1:WIDTH+1];
        endcase
        prod_nxt_s = {upper_s[UW-1], upper_s, prod_r[WIDTH:1]};
    end
`endif

    // Restoring division step on magnitudes: one quotient bit per cycle.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, dvsr_r};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shift_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final result/exception formation for the op that is finishing.
    always_comb begin
        full_prod_s = prod_r[2*WIDTH:1];
        fin_res_s   = {WIDTH{1'b0}};
        fin_exc_s   = 1'b0;
        if (op_mul_r) begin
            fin_res_s = full_prod_s[WIDTH-1:0];
            fin_exc_s = ~((&full_prod_s[2*WIDTH-1:WIDTH-1]) | ~(|full_prod_s[2*WIDTH-1:WIDTH-1]));
        end else if (b_r == {WIDTH{1'b0}}) begin
            fin_res_s = {WIDTH{1'b0}};
            fin_exc_s = 1'b1;
        end else begin
            // Magnitude quotient of MIN/-1 is already MIN with a positive sign.
            fin_res_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? (~quo_r + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_r;
            fin_exc_s = (a_r == MIN_NEG) && (b_r == {WIDTH{1'b1}});
        end
    end

    // Control FSM and iteration datapath; a valid start always wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            op_mul_r <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            prod_r   <= {PW{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            dvsr_r   <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            exc_r    <= 1'b0;
            rdy_r    <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            if (start_mul_s) begin
                state_r  <= ST_RUN_MUL;
                busy_r   <= 1'b1;
                cnt_r    <= {CNT_W{1'b0}};
                op_mul_r <= 1'b1;
                a_r      <= data_operandA;
                b_r      <= data_operandB;
                prod_r   <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
            end else if (start_div_s) begin
                state_r  <= ST_RUN_DIV;
                busy_r   <= 1'b1;
                cnt_r    <= {CNT_W{1'b0}};
                op_mul_r <= 1'b0;
                a_r      <= data_operandA;
                b_r      <= data_operandB;
                quo_r    <= mag(data_operandA);
                dvsr_r   <= mag(data_operandB);
                rem_r    <= {WIDTH{1'b0}};
            end else begin
                case (state_r)
                    ST_RUN_MUL: begin
                        prod_r <= prod_nxt_s;
                        cnt_r  <= cnt_r + CNT_ONE;
                        if (cnt_r == MUL_LAST) begin
                            state_r <= ST_FINISH;
                        end else begin
                            state_r <= ST_RUN_MUL;
                        end
                    end
                    ST_RUN_DIV: begin
                        quo_r <= quo_nxt_s;
                        rem_r <= rem_nxt_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == DIV_LAST) begin
                            state_r <= ST_FINISH;
                        end else begin
                            state_r <= ST_RUN_DIV;
                        end
                    end
                    ST_FINISH: begin
                        result_r <= fin_res_s;
                        exc_r    <= fin_exc_s;
                        rdy_r    <= 1'b1;
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_r;
    assign data_exception = exc_r;
    assign data_resultRDY = rdy_r;
    assign busy           = busy_r;

endmodule
